// File: rtl/pcu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pcu_pkg
// Description : Shared definitions for the second-generation PC unit:
//               branch-condition encodings, delay-slot FSM state encodings
//               and the exception vector offset.
// Revision    : 1.0 - initial release
// ============================================================================
package pcu_pkg;

  // Branch condition select (BrCond). Codes 6 and 7 are never taken.
  typedef logic [2:0] pcu_brcond_t;
  localparam pcu_brcond_t BR_EQ  = 3'd0;
  localparam pcu_brcond_t BR_NE  = 3'd1;
  localparam pcu_brcond_t BR_LEZ = 3'd2;
  localparam pcu_brcond_t BR_GTZ = 3'd3;
  localparam pcu_brcond_t BR_LTZ = 3'd4;
  localparam pcu_brcond_t BR_GEZ = 3'd5;

  // Delay-slot sequencing states.
  typedef logic [0:0] pcu_state_t;
  localparam pcu_state_t PCU_SEQ  = 1'b0;
  localparam pcu_state_t PCU_SLOT = 1'b1;

  // Exception handler lives at RESET_VECTOR + this offset.
  localparam logic [31:0] PCU_EXC_OFFSET = 32'h0000_0180;

endpackage
`default_nettype wire

// File: rtl/pcu_branch_cond.sv
`default_nettype none
// ============================================================================
// Module      : pcu_branch_cond
// Description : Combinational branch-condition evaluator. Turns the BrCond
//               select plus the ALU zero/sign flags into a taken flag.
//               Shared with the pipelined core's ID-stage comparator.
// Ports       : BrCond  in  3  condition select (BR_EQ..BR_GEZ)
//               ALUZero in  1  ALU result == 0
//               ALUNeg  in  1  ALU result sign bit
//               Taken   out 1  branch condition satisfied
// Revision    : 1.0 - initial release
// ============================================================================
module pcu_branch_cond
  import pcu_pkg::*;
(
  input  logic [2:0] BrCond,
  input  logic       ALUZero,
  input  logic       ALUNeg,
  output logic       Taken
);

  always_comb begin
    Taken = 1'b0;
    case (BrCond)
      BR_EQ:   Taken = ALUZero;
      BR_NE:   Taken = !ALUZero;
      BR_LEZ:  Taken = ALUZero || ALUNeg;
      BR_GTZ:  Taken = !ALUZero && !ALUNeg;
      BR_LTZ:  Taken = ALUNeg;
      BR_GEZ:  Taken = !ALUNeg;
      default: Taken = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/pc_unit_gen2.sv
`default_nettype none
// ============================================================================
// Module      : pc_unit_gen2
// Description : Program-counter unit. Holds the PC and selects the next PC
//               from sequential, branch, J/JAL and JR/JALR sources
//               (priority JumpReg > Jump > taken Branch > sequential).
//               DELAY_SLOT=1 inserts one architectural delay-slot
//               instruction before a taken redirect.
// Optional    : `define PCU_EXCEPTION_EN adds Exception/Eret/EPCIn inputs
//               and the EPC output.
// Ports       : CLK, RST (sync, active-high), Stall
//               Jump, JumpReg, Branch, BrCond[2:0], ALUZero, ALUNeg
//               JumpTarget[25:0], BranchOffset[W], RegTarget[W]
//               PCOut[W], PCPlus4[W], Redirect, AddrMisalign
//               (opt) Exception, Eret, EPCIn[W], EPC[W]
// Revision    : 1.0 - initial release
// ============================================================================
module pc_unit_gen2
  import pcu_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(32'h0000_3000),
  parameter int               DELAY_SLOT   = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Stall,
  input  logic             Jump,
  input  logic             JumpReg,
  input  logic             Branch,
  input  logic [2:0]       BrCond,
  input  logic             ALUZero,
  input  logic             ALUNeg,
  input  logic [25:0]      JumpTarget,
  input  logic [WIDTH-1:0] BranchOffset,
  input  logic [WIDTH-1:0] RegTarget,
`ifdef PCU_EXCEPTION_EN
  input  logic             Exception,
  input  logic             Eret,
  input  logic [WIDTH-1:0] EPCIn,
  output logic [WIDTH-1:0] EPC,
`endif
  output logic [WIDTH-1:0] PCOut,
  output logic [WIDTH-1:0] PCPlus4,
  output logic             Redirect,
  output logic             AddrMisalign
);

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_pending;
  pcu_state_t       r_state;
  logic             r_redirect;

  logic             w_taken;
  logic             w_nonSeq;
  logic [WIDTH-1:0] w_pcPlus4;
  logic [WIDTH-1:0] w_branchTarget;
  logic [WIDTH-1:0] w_jumpTarget;
  logic [WIDTH-1:0] w_target;
  logic [WIDTH-1:0] w_targetAligned;

  assign w_pcPlus4      = r_pc + WIDTH'(4);
  assign w_branchTarget = w_pcPlus4 + (BranchOffset << 2);
  assign w_jumpTarget   = {w_pcPlus4[WIDTH-1:28], JumpTarget, 2'b00};

  pcu_branch_cond u_brCond (
    .BrCond  (BrCond),
    .ALUZero (ALUZero),
    .ALUNeg  (ALUNeg),
    .Taken   (w_taken)
  );

  // Inline priority mux for the redirect source.
  always_comb begin
    w_target = w_pcPlus4;
    w_nonSeq = 1'b0;
    if (JumpReg) begin
      w_target = RegTarget;
      w_nonSeq = 1'b1;
    end else if (Jump) begin
      w_target = w_jumpTarget;
      w_nonSeq = 1'b1;
    end else if (Branch && w_taken) begin
      w_target = w_branchTarget;
      w_nonSeq = 1'b1;
    end
  end

  // A misaligned target is flagged but still loaded, word-aligned.
  assign w_targetAligned = {w_target[WIDTH-1:2], 2'b00};

  // In the delay slot the control inputs are ignored, so there is no
  // selected target to report on.
  assign AddrMisalign = w_nonSeq && (r_state == PCU_SEQ) && (w_target[1:0] != 2'b00);

`ifdef PCU_EXCEPTION_EN
  localparam logic [WIDTH-1:0] c_excVector = RESET_VECTOR + WIDTH'(PCU_EXC_OFFSET);
  logic [WIDTH-1:0] r_epc;
  assign EPC = r_epc;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pc       <= RESET_VECTOR;
      r_state    <= PCU_SEQ;
      r_pending  <= '0;
      r_redirect <= 1'b0;
`ifdef PCU_EXCEPTION_EN
      r_epc      <= '0;
    end else if (Exception) begin
      // In the slot the faulting context is the branch, one word back.
      r_epc      <= (r_state == PCU_SLOT) ? (r_pc - WIDTH'(4)) : r_pc;
      r_pc       <= c_excVector;
      r_state    <= PCU_SEQ;
      r_pending  <= '0;
      r_redirect <= 1'b1;
    end else if (Eret) begin
      r_pc       <= EPCIn;
      r_state    <= PCU_SEQ;
      r_pending  <= '0;
      r_redirect <= 1'b1;
`endif
    end else if (Stall) begin
      r_redirect <= 1'b0;
    end else if (DELAY_SLOT == 0) begin
      r_pc       <= w_nonSeq ? w_targetAligned : w_pcPlus4;
      r_redirect <= w_nonSeq;
    end else if (r_state == PCU_SLOT) begin
      r_pc       <= r_pending;
      r_redirect <= 1'b1;
      r_state    <= PCU_SEQ;
    end else begin
      // Fetch the delay-slot instruction first; redirect on the next cycle.
      r_pc       <= w_pcPlus4;
      r_redirect <= 1'b0;
      if (w_nonSeq) begin
        r_pending <= w_targetAligned;
        r_state   <= PCU_SLOT;
      end
    end
  end

  assign PCOut    = r_pc;
  assign PCPlus4  = w_pcPlus4;
  assign Redirect = r_redirect;

endmodule
`default_nettype wire
